// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clock_pkg
// Purpose : Shared definitions for the 12-hour clock: set-mode state
//           encodings and the time field widths used by the counter and
//           display logic.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2,
      ST_SET_SEC  = 2'd3
   } state_t;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   // Mode button cycles RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
   function automatic state_t next_mode(input state_t cur);
      case (cur)
         ST_RUN:      next_mode = ST_SET_HOUR;
         ST_SET_HOUR: next_mode = ST_SET_MIN;
         ST_SET_MIN:  next_mode = ST_SET_SEC;
         default:     next_mode = ST_RUN;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_auto_repeat.sv
`default_nettype none
// ============================================================================
// Module  : btn_auto_repeat
// Purpose : Rising-edge detect plus hold/auto-repeat for a debounced button.
//           Fires once on the press edge, again HOLD_CYC cycles after the
//           edge, then every REPEAT_CYC cycles while the button stays held.
// Ports   : clk     in  system clock
//           resetn  in  synchronous active-low reset
//           btn     in  debounced button level
//           fire    out single-cycle fire pulse (combinational from regs+btn)
// Revision: 1.0 - initial release
// ============================================================================
module btn_auto_repeat #(
   parameter int unsigned HOLD_CYC   = 50_000_000,
   parameter int unsigned REPEAT_CYC = 10_000_000
) (
   input  logic clk,
   input  logic resetn,
   input  logic btn,
   output logic fire
);

   localparam int HOLD_W = $clog2(HOLD_CYC + 1);
   localparam int REP_W  = $clog2(REPEAT_CYC + 1);

   logic              btn_q;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [REP_W-1:0]  rep_cnt, rep_nxt;
   logic              repeating, repeating_nxt;
   logic              btn_edge;

   assign btn_edge = btn & ~btn_q;

   // hold_cnt == 0 and !repeating means "not armed": a button held through
   // reset never produced an edge, so it must never start auto-repeating.
   always_comb begin
      fire          = 1'b0;
      hold_nxt      = hold_cnt;
      rep_nxt       = rep_cnt;
      repeating_nxt = repeating;
      if (!btn) begin
         hold_nxt      = '0;
         rep_nxt       = '0;
         repeating_nxt = 1'b0;
      end else if (btn_edge) begin
         fire          = 1'b1;
         hold_nxt      = HOLD_W'(1);
         rep_nxt       = '0;
         repeating_nxt = 1'b0;
      end else if (repeating) begin
         if (rep_cnt >= REP_W'(REPEAT_CYC)) begin
            fire    = 1'b1;
            rep_nxt = REP_W'(1);
         end else begin
            rep_nxt = rep_cnt + REP_W'(1);
         end
      end else if (hold_cnt != '0) begin
         if (hold_cnt >= HOLD_W'(HOLD_CYC)) begin
            fire          = 1'b1;
            repeating_nxt = 1'b1;
            rep_nxt       = REP_W'(1);
            hold_nxt      = '0;
         end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         btn_q     <= 1'b1;
         hold_cnt  <= '0;
         rep_cnt   <= '0;
         repeating <= 1'b0;
      end else begin
         btn_q     <= btn;
         hold_cnt  <= hold_nxt;
         rep_cnt   <= rep_nxt;
         repeating <= repeating_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clock_set_ctrl
// Purpose : Mode/sequencing controller for the 12-hour clock counter.
//           Converts mode/inc buttons and the 1 Hz tick into registered
//           single-cycle increment strobes, handles set-mode timeout and
//           blink of the selected field.
// Ports   : clk        in  system clock
//           resetn     in  synchronous active-low reset
//           tick_1hz   in  one-cycle pulse once per second
//           start_stop in  1 = timekeeping runs in RUN
//           mode_btn   in  debounced mode button level
//           inc_btn    in  debounced increment button level
//           sec_inc    out seconds increment strobe
//           min_inc    out minutes increment strobe
//           hour_inc   out hours increment strobe
//           carry_en   out counter carry enable (RUN only)
//           state_out  out current state encoding
//           blink      out blink for the selected field in SET states
// Revision: 1.0 - initial release
// ============================================================================
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned HOLD_CYC    = 50_000_000,
   parameter int unsigned REPEAT_CYC  = 10_000_000,
   parameter int unsigned TIMEOUT_SEC = 10
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       tick_1hz,
   input  logic       start_stop,
   input  logic       mode_btn,
   input  logic       inc_btn,
   output logic       sec_inc,
   output logic       min_inc,
   output logic       hour_inc,
   output logic       carry_en,
   output logic [1:0] state_out,
   output logic       blink
);

   localparam int TO_W = $clog2(TIMEOUT_SEC + 1);

   state_t          state, state_nxt;
   logic [TO_W-1:0] to_cnt, to_nxt;
   logic            mode_q;
   logic            mode_edge;
   logic            inc_fire;
   logic            blink_nxt, carry_nxt;
   logic            sec_nxt, min_nxt, hour_nxt;

   btn_auto_repeat #(
      .HOLD_CYC   (HOLD_CYC),
      .REPEAT_CYC (REPEAT_CYC)
   ) u_inc_rpt (
      .clk    (clk),
      .resetn (resetn),
      .btn    (inc_btn),
      .fire   (inc_fire)
   );

   assign mode_edge = mode_btn & ~mode_q;

   always_comb begin
      state_nxt = state;
      to_nxt    = to_cnt;
      blink_nxt = blink;
      sec_nxt   = 1'b0;
      min_nxt   = 1'b0;
      hour_nxt  = 1'b0;
      if (state == ST_RUN) begin
         to_nxt    = '0;
         blink_nxt = 1'b0;
         if (mode_edge) begin
            state_nxt = ST_SET_HOUR;
         end else if (tick_1hz && start_stop) begin
            sec_nxt = 1'b1;
         end
      end else begin
         if (mode_edge) begin
            // Mode wins over a coincident inc press or timeout expiry.
            state_nxt = next_mode(state);
            to_nxt    = '0;
            blink_nxt = 1'b0;
         end else begin
            if (tick_1hz) begin
               blink_nxt = ~blink;
            end
            if (inc_fire) begin
               case (state)
                  ST_SET_HOUR: hour_nxt = 1'b1;
                  ST_SET_MIN:  min_nxt  = 1'b1;
                  default:     sec_nxt  = 1'b1;
               endcase
               to_nxt = '0;
            end else if (tick_1hz) begin
               // The tick that would reach TIMEOUT_SEC returns to RUN, so
               // the counter stays bounded and never wraps.
               if (to_cnt >= TO_W'(TIMEOUT_SEC - 1)) begin
                  state_nxt = ST_RUN;
                  to_nxt    = '0;
                  blink_nxt = 1'b0;
               end else begin
                  to_nxt = to_cnt + TO_W'(1);
               end
            end
         end
      end
      carry_nxt = (state_nxt == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= ST_RUN;
         to_cnt   <= '0;
         mode_q   <= 1'b1;
         blink    <= 1'b0;
         carry_en <= 1'b1;
         sec_inc  <= 1'b0;
         min_inc  <= 1'b0;
         hour_inc <= 1'b0;
      end else begin
         state    <= state_nxt;
         to_cnt   <= to_nxt;
         mode_q   <= mode_btn;
         blink    <= blink_nxt;
         carry_en <= carry_nxt;
         sec_inc  <= sec_nxt;
         min_inc  <= min_nxt;
         hour_inc <= hour_nxt;
      end
   end

   assign state_out = state;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_set_ctrl
// Purpose : Directed self-checking bench for clock_set_ctrl with
//           HOLD_CYC=8, REPEAT_CYC=4, TIMEOUT_SEC=3.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       resetn, tick_1hz, start_stop, mode_btn, inc_btn;
   logic       sec_inc, min_inc, hour_inc, carry_en, blink;
   logic [1:0] state_out;

   int n_checks = 0;
   int n_pass   = 0;

   clock_set_ctrl #(
      .HOLD_CYC    (8),
      .REPEAT_CYC  (4),
      .TIMEOUT_SEC (3)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .tick_1hz   (tick_1hz),
      .start_stop (start_stop),
      .mode_btn   (mode_btn),
      .inc_btn    (inc_btn),
      .sec_inc    (sec_inc),
      .min_inc    (min_inc),
      .hour_inc   (hour_inc),
      .carry_en   (carry_en),
      .state_out  (state_out),
      .blink      (blink)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then stable for sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; mode_btn = 1'b1;
      repeat (3) step();
      n_checks++; if (state_out !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state_out); else n_pass++;
      n_checks++; if (carry_en !== 1'b1) $display("FAIL reset_carry got=%b exp=1", carry_en); else n_pass++;
      n_checks++; if (blink !== 1'b0) $display("FAIL reset_blink got=%b exp=0", blink); else n_pass++;
      n_checks++; if ({sec_inc, min_inc, hour_inc} !== 3'b000)
         $display("FAIL reset_strobes got=%b exp=000", {sec_inc, min_inc, hour_inc}); else n_pass++;
      resetn = 1'b1;
      step(); step();
      n_checks++; if (state_out !== 2'd0) $display("FAIL reset_held_mode got=%0d exp=0", state_out); else n_pass++;
      mode_btn = 1'b0;
      step();
      n_checks++; if (state_out !== 2'd0) $display("FAIL reset_mode_release got=%0d exp=0", state_out); else n_pass++;
   endtask

   task automatic test_run_ticks();
      int cnt;
      cnt = 0;
      start_stop = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick_1hz = 1'b1;
         step();
         n_checks++; if (sec_inc !== 1'b1) $display("FAIL run_tick_latency i=%0d got=%b exp=1", i, sec_inc); else n_pass++;
         if (sec_inc === 1'b1) cnt++;
         tick_1hz = 1'b0;
         step();
         if (sec_inc === 1'b1) cnt++;
         step();
         if (sec_inc === 1'b1) cnt++;
      end
      n_checks++; if (cnt != 5) $display("FAIL run_tick_count got=%0d exp=5", cnt); else n_pass++;
      start_stop = 1'b0;
      tick_1hz = 1'b1;
      step();
      n_checks++; if (sec_inc !== 1'b0) $display("FAIL run_stopped got=%b exp=0", sec_inc); else n_pass++;
      tick_1hz = 1'b0;
      start_stop = 1'b1;
      step();
   endtask

   task automatic test_set_hour();
      int hcnt;
      mode_btn = 1'b1;
      step();
      n_checks++; if (state_out !== 2'd1) $display("FAIL sethour_state got=%0d exp=1", state_out); else n_pass++;
      n_checks++; if (carry_en !== 1'b0) $display("FAIL sethour_carry got=%b exp=0", carry_en); else n_pass++;
      mode_btn = 1'b0;
      step();
      inc_btn = 1'b1;
      step();
      n_checks++; if ({sec_inc, min_inc, hour_inc} !== 3'b001)
         $display("FAIL sethour_inc got=%b exp=001", {sec_inc, min_inc, hour_inc}); else n_pass++;
      inc_btn = 1'b0;
      hcnt = 0;
      repeat (4) begin
         step();
         if (hour_inc || min_inc || sec_inc) hcnt++;
      end
      n_checks++; if (hcnt != 0) $display("FAIL sethour_extra_strobes got=%0d exp=0", hcnt); else n_pass++;
      tick_1hz = 1'b1;
      step();
      n_checks++; if (blink !== 1'b1) $display("FAIL sethour_blink got=%b exp=1", blink); else n_pass++;
      n_checks++; if (sec_inc !== 1'b0) $display("FAIL sethour_frozen got=%b exp=0", sec_inc); else n_pass++;
      tick_1hz = 1'b0;
      step();
   endtask

   task automatic test_simultaneous();
      mode_btn = 1'b1; inc_btn = 1'b1;
      step();
      n_checks++; if (state_out !== 2'd2) $display("FAIL simul_state got=%0d exp=2", state_out); else n_pass++;
      n_checks++; if ({hour_inc, min_inc} !== 2'b00)
         $display("FAIL simul_strobes got=%b exp=00", {hour_inc, min_inc}); else n_pass++;
      n_checks++; if (blink !== 1'b0) $display("FAIL simul_blink got=%b exp=0", blink); else n_pass++;
      mode_btn = 1'b0; inc_btn = 1'b0;
      step();
      n_checks++; if (min_inc !== 1'b0) $display("FAIL simul_after got=%b exp=0", min_inc); else n_pass++;
      step();
   endtask

   task automatic test_hold_repeat();
      int cnt;
      int bad;
      logic exp;
      cnt = 0; bad = 0;
      inc_btn = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         step();
         exp = (k == 0) || (k == 8) || (k == 12) || (k == 16) || (k == 20);
         if (min_inc === 1'b1) cnt++;
         if (min_inc !== exp || hour_inc !== 1'b0 || sec_inc !== 1'b0) bad++;
      end
      inc_btn = 1'b0;
      step();
      if (min_inc === 1'b1) cnt++;
      n_checks++; if (cnt != 5) $display("FAIL hold_count got=%0d exp=5", cnt); else n_pass++;
      n_checks++; if (bad != 0) $display("FAIL hold_timing bad_cycles got=%0d exp=0", bad); else n_pass++;
      n_checks++; if (state_out !== 2'd2) $display("FAIL hold_state got=%0d exp=2", state_out); else n_pass++;
   endtask

   task automatic test_timeout();
      mode_btn = 1'b1;
      step();
      n_checks++; if (state_out !== 2'd3) $display("FAIL to_setsec got=%0d exp=3", state_out); else n_pass++;
      mode_btn = 1'b0;
      step();
      tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
      n_checks++; if (blink !== 1'b1) $display("FAIL to_blink1 got=%b exp=1", blink); else n_pass++;
      step();
      tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
      n_checks++; if (state_out !== 2'd3) $display("FAIL to_state2 got=%0d exp=3", state_out); else n_pass++;
      n_checks++; if (blink !== 1'b0) $display("FAIL to_blink2 got=%b exp=0", blink); else n_pass++;
      step();
      tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
      n_checks++; if (state_out !== 2'd0) $display("FAIL to_state3 got=%0d exp=0", state_out); else n_pass++;
      n_checks++; if (blink !== 1'b0) $display("FAIL to_blink3 got=%b exp=0", blink); else n_pass++;
      n_checks++; if (carry_en !== 1'b1) $display("FAIL to_carry got=%b exp=1", carry_en); else n_pass++;
      n_checks++; if (sec_inc !== 1'b0) $display("FAIL to_sec_inc got=%b exp=0", sec_inc); else n_pass++;
      step();
   endtask

   task automatic test_reset_mid_repeat();
      mode_btn = 1'b1; step(); mode_btn = 1'b0; step();
      inc_btn = 1'b1;
      repeat (12) step();
      resetn = 1'b0;
      step();
      n_checks++; if (state_out !== 2'd0) $display("FAIL rstmid_state got=%0d exp=0", state_out); else n_pass++;
      n_checks++; if ({sec_inc, min_inc, hour_inc} !== 3'b000)
         $display("FAIL rstmid_strobes got=%b exp=000", {sec_inc, min_inc, hour_inc}); else n_pass++;
      resetn = 1'b1;
      step();
      inc_btn = 1'b0;
      step();
   endtask

   initial begin
      resetn = 1'b0; tick_1hz = 1'b0; start_stop = 1'b0;
      mode_btn = 1'b0; inc_btn = 1'b0;
      #1;
      test_reset();
      test_run_ticks();
      test_set_hour();
      test_simultaneous();
      test_hold_repeat();
      test_timeout();
      test_reset_mid_repeat();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
